mac_array_ws: RTL and testbench
===============================

Name: mac_array_ws

Overview:
- Weight-stationary systolic MAC array of MAC_ROW x MAC_COL processing elements (PEs).
- Weights are preloaded column-wise through a vertical shift chain. Ifmap vectors enter on the left, one element per row, and travel rightward. Partial sums travel downward.
- Each column emits a stream of dot products (ifmap vector · column weights) at its bottom edge. It is the compute core fed by the ifmap/weight buffers of the TPU datapath.

Parameters:
- MAC_ROW, 16, number of PE rows (dot-product length)
- MAC_COL, 16, number of PE columns (output channels)
- IFMAP_BITWIDTH, 16, signed ifmap element width
- W_BITWIDTH, 8, signed weight width
- OFMAP_BITWIDTH, 32, signed accumulator/output width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- w_prefetch_in  in  1  one-cycle pulse: begin weight load
- w_enable_in  in  1  weight shift enable
- w_data_in  in  MAC_COL x W_BITWIDTH (packed, signed)  one weight per column per cycle
- ifmap_start_in  in  1  one-cycle pulse: begin new ifmap pass
- ifmap_enable_in  in  MAC_ROW  per-row ifmap valid (caller applies row skew)
- ifmap_data_in  in  MAC_ROW x IFMAP_BITWIDTH (packed, signed)  per-row ifmap element
- ofmap_valid_out  out  MAC_COL  per-column output valid
- ofmap_data_out  out  MAC_COL x OFMAP_BITWIDTH (packed)  per-column dot product

Behaviour:
- Reset (rstn=0 at a clk edge): clear all weight, ifmap, enable, partial-sum and valid registers to 0. Outputs read 0 after that edge. Reset mid-operation aborts everything and discards in-flight data.
- Weight load:
  - w_prefetch_in=1 clears all weight registers.
  - On each edge with w_enable_in=1: W[0][c] <= w_data_in[c] and W[r][c] <= W[r-1][c].
  - After MAC_ROW enabled cycles, the value supplied on cycle k (k=0..MAC_ROW-1) sits in row MAC_ROW-1-k, i.e. the caller sends the bottom row first.
  - Weights hold when w_enable_in=0.
  - No double buffering: shifting during compute takes effect immediately.
- Ifmap flow:
  - PE(r,c) input x_in(r,c) is ifmap_data_in[r] for c=0, else X[r][c-1].
  - Enable e_in(r,c) is ifmap_enable_in[r] for c=0, else E[r][c-1].
  - Each edge: X[r][c] <= x_in(r,c) and E[r][c] <= e_in(r,c).
- Partial sums:
  - Each edge: P[r][c] <= P_above + (e_in(r,c) ? x_in*W[r][c] : 0). P_above = 0 for r=0, else P[r-1][c].
  - V[r][c] <= e_in(r,c).
- Arithmetic:
  - Product is a signed IFMAP_BITWIDTH x W_BITWIDTH multiply, sign-extended to OFMAP_BITWIDTH.
  - Sums wrap modulo 2^OFMAP_BITWIDTH with no saturation.
- Outputs: ofmap_data_out[c] = P[MAC_ROW-1][c] and ofmap_valid_out[c] = V[MAC_ROW-1][c], both registered.
- Skew contract: the caller drives row r exactly r cycles after row 0 for the same vector index n.
- Latency: if row 0 of vector n is sampled at edge T, column c shows the result for vector n, with valid=1, after edge T+MAC_ROW-1+c.
  - Results per column come out in input order, one per cycle, with no gaps for back-to-back input.
  - Valid per column is high for exactly as many cycles as vectors fed, and columns are staggered by one cycle.
- ifmap_start_in=1 clears all X, E, P, V registers (weights kept). Use it only between passes.
- If w_prefetch_in and w_enable_in are both 1 on the same edge, clear the weights first and then shift w_data_in into row 0.
- If ifmap_start_in and ifmap_enable_in are both 1 on the same edge, clear the pipeline and also capture the row-0 inputs.

Test Plan:
- Load all weights = 1; feed one skewed vector with ifmap[r] = r+1. Every column outputs 136 with valid=1 for one cycle. Column c valid appears after edge T+15+c.
- Load W[r][c] = (c==r) ? 1 : 0; feed 4 vectors with ifmap[r][n] = 100*n+r. Column c outputs 100*n+c for n=0..3, in order, on consecutive cycles.
- Signed extremes: all weights 0x80 (-128), all ifmap 0x8000 (-32768). Each column outputs 16*4194304 = 67108864 (0x04000000).
- Negative mix: weights -1 (0xFF), ifmap 0x7FFF. Each output is -524272 (0xFFF80010).
- Deassert rstn for 1 cycle mid-stream. All ofmap_valid_out go 0 on the next edge. After reloading weights and refeeding, results are correct.
- Random weights, 1024 random skewed vectors back-to-back. Every column matches the golden dot products: 1024 valid outputs each, error count 0.

Source files
------------

// File: rtl/mac_array_ws.sv
// Weight-stationary systolic MAC array: weights shift down from row 0, ifmaps flow right,
// partial sums flow down, and each column's bottom PE emits one dot product per valid vector.

module mac_pe #(
    parameter int IW = 16,
    parameter int WW = 8,
    parameter int OW = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 w_clear,
    input  logic                 w_shift,
    input  logic        [WW-1:0] w_up,
    input  logic signed [IW-1:0] x_left,
    input  logic                 e_left,
    input  logic        [OW-1:0] p_up,
    output logic        [WW-1:0] w,
    output logic        [IW-1:0] x,
    output logic                 e,
    output logic        [OW-1:0] p,
    output logic                 v
);
    logic signed [OW-1:0] x_ext;
    logic signed [OW-1:0] w_ext;
    logic        [OW-1:0] prod;

    // Both operands are sign-extended to OW first, so the low OW bits are the exact
    // signed product and accumulation simply wraps modulo 2^OW.
    assign x_ext = OW'(x_left);
    assign w_ext = OW'($signed(w));
    assign prod  = x_ext * w_ext;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w <= '0;
        end else if (w_shift) begin
            w <= w_up;
        end else if (w_clear) begin
            w <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            x <= '0;
            e <= 1'b0;
            p <= '0;
            v <= 1'b0;
        end else begin
            x <= x_left;
            e <= e_left;
            p <= p_up + (e_left ? prod : '0);
            v <= e_left;
        end
    end
endmodule

module mac_array_ws #(
    parameter int MAC_ROW        = 16,
    parameter int MAC_COL        = 16,
    parameter int IFMAP_BITWIDTH = 16,
    parameter int W_BITWIDTH     = 8,
    parameter int OFMAP_BITWIDTH = 32
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         w_prefetch_in,
    input  logic                                         w_enable_in,
    input  logic [MAC_COL-1:0][W_BITWIDTH-1:0]           w_data_in,
    input  logic                                         ifmap_start_in,
    input  logic [MAC_ROW-1:0]                           ifmap_enable_in,
    input  logic [MAC_ROW-1:0][IFMAP_BITWIDTH-1:0]       ifmap_data_in,
    output logic [MAC_COL-1:0]                           ofmap_valid_out,
    output logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0]       ofmap_data_out
);
    localparam int IW = IFMAP_BITWIDTH;
    localparam int WW = W_BITWIDTH;
    localparam int OW = OFMAP_BITWIDTH;

    logic [MAC_ROW-1:0][MAC_COL-1:0][WW-1:0] w_q;
    logic [MAC_ROW-1:0][MAC_COL-1:0][IW-1:0] x_q;
    logic [MAC_ROW-1:0][MAC_COL-1:0]         e_q;
    logic [MAC_ROW-1:0][MAC_COL-1:0][OW-1:0] p_q;
    logic [MAC_ROW-1:0][MAC_COL-1:0]         v_q;

    logic [MAC_ROW-1:0] unused_row;
    logic               unused_tail;

    for (genvar r = 0; r < MAC_ROW; r++) begin : g_row
        // Rightmost ifmap/enable registers have no consumer.
        assign unused_row[r] = ^{x_q[r][MAC_COL-1], e_q[r][MAC_COL-1]};

        for (genvar c = 0; c < MAC_COL; c++) begin : g_col
            logic [WW-1:0] w_src;
            logic [IW-1:0] x_src;
            logic          e_src;
            logic [OW-1:0] p_src;

            // A clear pulse zeroes the neighbour values seen this edge, which is the same as
            // clearing first and then shifting/capturing the external inputs.
            if (r == 0) begin : g_top
                assign w_src = w_data_in[c];
                assign p_src = '0;
            end else begin : g_inner
                assign w_src = w_prefetch_in  ? '0 : w_q[r-1][c];
                assign p_src = ifmap_start_in ? '0 : p_q[r-1][c];
            end

            if (c == 0) begin : g_left
                assign x_src = ifmap_data_in[r];
                assign e_src = ifmap_enable_in[r];
            end else begin : g_mid
                assign x_src = ifmap_start_in ? '0   : x_q[r][c-1];
                assign e_src = ifmap_start_in ? 1'b0 : e_q[r][c-1];
            end

            mac_pe #(
                .IW(IW),
                .WW(WW),
                .OW(OW)
            ) u_pe (
                .clk     (clk),
                .rstn    (rstn),
                .w_clear (w_prefetch_in),
                .w_shift (w_enable_in),
                .w_up    (w_src),
                .x_left  (x_src),
                .e_left  (e_src),
                .p_up    (p_src),
                .w       (w_q[r][c]),
                .x       (x_q[r][c]),
                .e       (e_q[r][c]),
                .p       (p_q[r][c]),
                .v       (v_q[r][c])
            );
        end
    end

    assign unused_tail = ^{unused_row, w_q[MAC_ROW-1]};

    assign ofmap_data_out  = p_q[MAC_ROW-1];
    assign ofmap_valid_out = v_q[MAC_ROW-1];
endmodule

// File: tb/tb_mac_array_ws.sv
// Directed + random bench for mac_array_ws; golden results are plain dot products of the
// loaded weight matrix with each fed vector, with timing taken from the latency rule.

module tb_mac_array_ws;
    localparam int R    = 16;
    localparam int C    = 16;
    localparam int IW   = 16;
    localparam int WW   = 8;
    localparam int OW   = 32;
    localparam int MAXV = 1024;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     w_prefetch_in;
    logic                     w_enable_in;
    logic [C-1:0][WW-1:0]     w_data_in;
    logic                     ifmap_start_in;
    logic [R-1:0]             ifmap_enable_in;
    logic [R-1:0][IW-1:0]     ifmap_data_in;
    logic [C-1:0]             ofmap_valid_out;
    logic [C-1:0][OW-1:0]     ofmap_data_out;

    int n_assert = 0;
    int n_fail   = 0;
    int wm [R][C];
    int xv [MAXV][R];

    mac_array_ws #(
        .MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .OFMAP_BITWIDTH(OW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .w_prefetch_in   (w_prefetch_in),
        .w_enable_in     (w_enable_in),
        .w_data_in       (w_data_in),
        .ifmap_start_in  (ifmap_start_in),
        .ifmap_enable_in (ifmap_enable_in),
        .ifmap_data_in   (ifmap_data_in),
        .ofmap_valid_out (ofmap_valid_out),
        .ofmap_data_out  (ofmap_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dot(input int n, input int c);
        int acc = 0;
        for (int r = 0; r < R; r++) acc += xv[n][r] * wm[r][c];
        return acc;
    endfunction

    // Bottom row first; optional idle gaps and a prefetch merged into the first shift.
    task automatic load_weights(input bit gaps, input bit combined);
        if (!combined) begin
            w_prefetch_in = 1'b1;
            w_enable_in   = 1'b0;
            tick();
        end
        for (int k = 0; k < R; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                w_prefetch_in = 1'b0;
                w_enable_in   = 1'b0;
                for (int c = 0; c < C; c++) w_data_in[c] = WW'($urandom);
                tick();
            end
            w_prefetch_in = combined && (k == 0);
            w_enable_in   = 1'b1;
            for (int c = 0; c < C; c++) w_data_in[c] = wm[R-1-k][c][WW-1:0];
            tick();
        end
        w_prefetch_in = 1'b0;
        w_enable_in   = 1'b0;
    endtask

    task automatic drive_skewed(input int t, input int n);
        for (int r = 0; r < R; r++) begin
            if (t - r >= 0 && t - r < n) begin
                ifmap_enable_in[r] = 1'b1;
                ifmap_data_in[r]   = xv[t-r][r][IW-1:0];
            end else begin
                ifmap_enable_in[r] = 1'b0;
                ifmap_data_in[r]   = IW'($urandom);
            end
        end
    endtask

    task automatic start_pulse();
        ifmap_start_in  = 1'b1;
        ifmap_enable_in = '0;
        tick();
        ifmap_start_in  = 1'b0;
    endtask

    // Row 0 of vector n is sampled at edge n, so column c must present it right after
    // edge n+R-1+c; valid must be low at every other sample.
    task automatic run_pass(input string name, input int n);
        int cnt [C];
        for (int c = 0; c < C; c++) cnt[c] = 0;
        start_pulse();
        for (int t = 0; t < n + R + C + 2; t++) begin
            drive_skewed(t, n);
            tick();
            for (int c = 0; c < C; c++) begin
                int  idx   = t - (R - 1 + c);
                bit  exp_v = (idx >= 0) && (idx < n);
                check($sformatf("%s valid c%0d t%0d", name, c, t), 32'(ofmap_valid_out[c]), 32'(exp_v));
                if (exp_v) begin
                    check($sformatf("%s data c%0d v%0d", name, c, idx), ofmap_data_out[c], dot(idx, c));
                end
                if (ofmap_valid_out[c]) cnt[c]++;
            end
        end
        ifmap_enable_in = '0;
        for (int c = 0; c < C; c++) check($sformatf("%s count c%0d", name, c), cnt[c], n);
    endtask

    initial begin
        rstn            = 1'b0;
        w_prefetch_in   = 1'b0;
        w_enable_in     = 1'b0;
        w_data_in       = '0;
        ifmap_start_in  = 1'b0;
        ifmap_enable_in = '0;
        ifmap_data_in   = '0;
        tick();
        tick();
        for (int c = 0; c < C; c++) begin
            check($sformatf("reset valid c%0d", c), 32'(ofmap_valid_out[c]), 32'd0);
            check($sformatf("reset data c%0d", c), ofmap_data_out[c], 32'd0);
        end
        rstn = 1'b1;
        tick();

        // All-ones weights, ifmap r+1: every column gives 136.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = 1;
        for (int r = 0; r < R; r++) xv[0][r] = r + 1;
        load_weights(1'b0, 1'b0);
        check("ones golden", dot(0, 3), 32'd136);
        run_pass("ones", 1);

        // Identity weights: column c returns element c of each vector.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = (r == c) ? 1 : 0;
        for (int n = 0; n < 4; n++) for (int r = 0; r < R; r++) xv[n][r] = 100 * n + r;
        load_weights(1'b0, 1'b0);
        run_pass("ident", 4);

        // Most-negative operands.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = -128;
        for (int n = 0; n < 2; n++) for (int r = 0; r < R; r++) xv[n][r] = -32768;
        load_weights(1'b0, 1'b0);
        check("extreme golden", dot(0, 0), 32'h0400_0000);
        run_pass("extreme", 2);

        // Weight -1 against max positive ifmap.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = -1;
        for (int r = 0; r < R; r++) xv[0][r] = 32767;
        load_weights(1'b0, 1'b0);
        check("negmix golden", dot(0, 0), 32'hFFF8_0010);
        run_pass("negmix", 1);

        // Reset in the middle of a stream discards everything in flight.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < 20; n++) for (int r = 0; r < R; r++) xv[n][r] = int'($urandom_range(0, 65535)) - 32768;
        load_weights(1'b0, 1'b0);
        start_pulse();
        for (int t = 0; t < 24; t++) begin
            drive_skewed(t, 20);
            tick();
        end
        ifmap_enable_in = '0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < C; c++) begin
            check($sformatf("midrst valid c%0d", c), 32'(ofmap_valid_out[c]), 32'd0);
            check($sformatf("midrst data c%0d", c), ofmap_data_out[c], 32'd0);
        end
        for (int t = 0; t < R + C; t++) begin
            tick();
            check($sformatf("postrst idle t%0d", t), 32'(ofmap_valid_out), 32'd0);
        end
        load_weights(1'b1, 1'b0);
        run_pass("refeed", 20);

        // Random weights (gapped load, prefetch merged with first shift), 1024 back-to-back vectors.
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) wm[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < MAXV; n++) for (int r = 0; r < R; r++) xv[n][r] = int'($urandom_range(0, 65535)) - 32768;
        load_weights(1'b1, 1'b1);
        run_pass("random", MAXV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
